// File: rtl/kurs_pkg.sv
// Shared types and constants for the BCD to excess-3 conversion scheduler.
// Holds the FSM state encoding and the code range limits.
package kurs_pkg;

    localparam int CODE_W = 4;

    localparam logic [CODE_W-1:0] XS3_OFFSET = 4'd3;
    localparam logic [CODE_W-1:0] BCD_MAX    = 4'd9;
    localparam logic [CODE_W-1:0] XS3_MIN    = 4'd3;
    localparam logic [CODE_W-1:0] XS3_MAX    = 4'd12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        CONV  = 2'd2,
        OUT   = 2'd3
    } state_e;

endpackage

// File: rtl/code_conv.sv
// Combinational BCD to excess-3 converter with input/output range flags.
// Shared by all requesters of the scheduler.
module code_conv
    import kurs_pkg::*;
(
    input  logic [CODE_W-1:0] code_i,
    output logic [CODE_W-1:0] code_o,
    output logic              in_bad_o,
    output logic              out_bad_o
);

    // Addition wraps naturally at the code width.
    assign code_o    = code_i + XS3_OFFSET;
    assign in_bad_o  = (code_i > BCD_MAX);
    assign out_bad_o = (code_o < XS3_MIN) || (code_o > XS3_MAX);

endmodule

// File: rtl/code_conv_scheduler.sv
// Round-robin scheduler sharing one code converter among N_REQ requesters.
// Tracks a running up/down sum and a saturating error count of results.
module code_conv_scheduler
    import kurs_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int SUM_W = 4,
    parameter int ERR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [4*N_REQ-1:0]    req_code,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [CODE_W-1:0]     res_code,
    output logic [1:0]            res_src,
    output logic                  res_err,
    output logic [SUM_W-1:0]      sum,
    output logic [ERR_W-1:0]      err_cnt
);

    state_e              state_q;
    logic [1:0]          last_q;
    logic [1:0]          sel_q;
    logic [CODE_W-1:0]   code_q;
    logic [N_REQ-1:0]    ready_q;
    logic                res_valid_q;
    logic [CODE_W-1:0]   res_code_q;
    logic [1:0]          res_src_q;
    logic                res_err_q;
    logic [SUM_W-1:0]    sum_q;
    logic [ERR_W-1:0]    err_q;

    logic [3:0]          valid_pad;
    logic [15:0]         code_pad;
    logic                any_v;
    logic [1:0]          sel_d;
    logic                found;
    logic [2:0]          cand;
    logic [N_REQ-1:0]    grant_oh;
    logic [CODE_W-1:0]   conv_code;
    logic                conv_in_bad;
    logic                conv_out_bad;
    logic [SUM_W-1:0]    sum_d;
    logic [ERR_W-1:0]    err_d;

    assign valid_pad = 4'(req_valid);
    assign code_pad  = 16'(req_code);
    assign any_v     = |req_valid;

    // Search starts one past the last granted requester.
    always_comb begin
        sel_d = last_q;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = {1'b0, last_q} + 3'(k);
            if (cand >= 3'(N_REQ)) begin
                cand = cand - 3'(N_REQ);
            end
            if (!found && valid_pad[cand[1:0]]) begin
                found = 1'b1;
                sel_d = cand[1:0];
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            grant_oh[i] = (sel_d == 2'(i));
        end
    end

    code_conv u_conv (
        .code_i    (code_q),
        .code_o    (conv_code),
        .in_bad_o  (conv_in_bad),
        .out_bad_o (conv_out_bad)
    );

    // Only clean, non-zero results move the sum; odd codes count down.
    always_comb begin
        sum_d = sum_q;
        if (!res_err_q && (res_code_q != '0)) begin
            if (res_code_q[0]) begin
                sum_d = sum_q - SUM_W'(1);
            end else begin
                sum_d = sum_q + SUM_W'(1);
            end
        end
    end

    always_comb begin
        err_d = err_q;
        if (res_err_q && (err_q != '1)) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= 2'(N_REQ - 1);
            sel_q       <= '0;
            code_q      <= '0;
            ready_q     <= '0;
            res_valid_q <= 1'b0;
            res_code_q  <= '0;
            res_src_q   <= '0;
            res_err_q   <= 1'b0;
            sum_q       <= '0;
            err_q       <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_v) begin
                        state_q <= GRANT;
                        sel_q   <= sel_d;
                        ready_q <= grant_oh;
                    end
                end
                GRANT: begin
                    ready_q <= '0;
                    if (valid_pad[sel_q]) begin
                        code_q  <= code_pad[{sel_q, 2'b00} +: 4];
                        last_q  <= sel_q;
                        state_q <= CONV;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CONV: begin
                    res_code_q  <= conv_code;
                    res_err_q   <= conv_in_bad | conv_out_bad;
                    res_src_q   <= sel_q;
                    res_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        sum_q       <= sum_d;
                        err_q       <= err_d;
                        if (any_v) begin
                            state_q <= GRANT;
                            sel_q   <= sel_d;
                            ready_q <= grant_oh;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = ready_q;
    assign res_valid = res_valid_q;
    assign res_code  = res_code_q;
    assign res_src   = res_src_q;
    assign res_err   = res_err_q;
    assign sum       = sum_q;
    assign err_cnt   = err_q;

endmodule

// File: tb/tb_code_conv_scheduler.sv
// Randomized bench for code_conv_scheduler against a transaction-level model.
// Model predicts grants, results, sum and error count from the stimulus alone.
module tb_code_conv_scheduler;

    localparam int N  = 2;
    localparam int SW = 4;
    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [4*N-1:0] req_code = '0;
    logic [N-1:0]  req_ready;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [3:0]    res_code;
    logic [1:0]    res_src;
    logic          res_err;
    logic [SW-1:0] sum;
    logic [EW-1:0] err_cnt;

    always #5 clk = ~clk;

    code_conv_scheduler #(
        .N_REQ (N),
        .SUM_W (SW),
        .ERR_W (EW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_code  (req_code),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_code  (res_code),
        .res_src   (res_src),
        .res_err   (res_err),
        .sum       (sum),
        .err_cnt   (err_cnt)
    );

    typedef struct {
        int code;
        int err;
        int src;
        int acc;
    } item_t;

    item_t         q[$];
    int            cyc;
    int            ptr;
    int            errors;
    int            checks;
    logic [N-1:0]  exp_ready;
    logic [SW-1:0] m_sum;
    logic [EW-1:0] m_err;
    logic [N-1:0]  acc_flag;

    int            raise_pct;
    int            drop_pct;
    int            rdy_pct;
    int            code_mode;
    int            fix_code[N];
    logic [N-1:0]  inj_v;
    int            inj_code[N];
    bit            rst_done;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int pick(int p, logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (p + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int gen_code(int i);
        case (code_mode)
            0:       return fix_code[i];
            1:       return int'($urandom_range(15));
            2:       return int'($urandom_range(15, 10));
            default: return int'($urandom_range(9));
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        ptr       = N - 1;
        exp_ready = '0;
        m_sum     = '0;
        m_err     = '0;
        acc_flag  = '0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (inj_v[i]) begin
                req_valid[i] = 1'b1;
                req_code[4*i +: 4] = 4'(inj_code[i]);
            end else if (acc_flag[i] || !req_valid[i]) begin
                if (int'($urandom_range(99)) < raise_pct) begin
                    req_valid[i] = 1'b1;
                    req_code[4*i +: 4] = 4'(gen_code(i));
                end else begin
                    req_valid[i] = 1'b0;
                end
            end else if (int'($urandom_range(99)) < drop_pct) begin
                req_valid[i] = 1'b0;
            end
        end
        inj_v     = '0;
        acc_flag  = '0;
        res_ready = (int'($urandom_range(99)) < rdy_pct);
    endtask

    task automatic compare();
        bit rv;
        rv = (q.size() > 0) && (cyc >= q[0].acc + 2);
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("res_valid", 32'(res_valid), 32'(rv));
        if (rv) begin
            check("res_code", 32'(res_code), 32'(q[0].code));
            check("res_src", 32'(res_src), 32'(q[0].src));
            check("res_err", 32'(res_err), 32'(q[0].err));
        end
        check("sum", 32'(sum), 32'(m_sum));
        check("err_cnt", 32'(err_cnt), 32'(m_err));
    endtask

    task automatic step();
        bit           rv;
        bit           hs;
        logic [N-1:0] nr;
        item_t        it;
        int           g;
        int           c;
        rv = (q.size() > 0) && (cyc >= q[0].acc + 2);
        hs = rv && res_ready;
        nr = '0;
        if ((|req_valid) && (((q.size() == 0) && (exp_ready == '0)) || hs)) begin
            nr[pick(ptr, req_valid)] = 1'b1;
        end
        if (hs) begin
            it = q.pop_front();
            if (it.err != 0) begin
                if (m_err != '1) m_err = m_err + 1'b1;
            end else if (it.code != 0) begin
                if (it.code % 2 == 1) m_sum = m_sum - 1'b1;
                else                  m_sum = m_sum + 1'b1;
            end
        end
        if ((exp_ready & req_valid) != '0) begin
            g = 0;
            for (int i = 0; i < N; i++) if (exp_ready[i]) g = i;
            c = int'(req_code[4*g +: 4]);
            it.code = (c + 3) % 16;
            it.err  = (c > 9 || it.code < 3 || it.code > 12) ? 1 : 0;
            it.src  = g;
            it.acc  = cyc;
            q.push_back(it);
            ptr = g;
            acc_flag[g] = 1'b1;
        end
        exp_ready = nr;
        cyc++;
    endtask

    task automatic reset_checks(string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_res_code"}, 32'(res_code), 32'd0);
        check({tag, "_res_src"}, 32'(res_src), 32'd0);
        check({tag, "_res_err"}, 32'(res_err), 32'd0);
        check({tag, "_sum"}, 32'(sum), 32'd0);
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    endtask

    task automatic run(int n, bit rst_in_conv);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rst_in_conv && !rst_done && q.size() > 0 && cyc == q[0].acc + 1) begin
                rst_n = 1'b0;
                #1;
                reset_checks("midrst");
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
                rst_done = 1'b1;
            end
            compare();
            drive();
            step();
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        cyc      = 0;
        rst_done = 1'b0;
        inj_v    = '0;
        model_reset();
        raise_pct = 0;
        drop_pct  = 0;
        rdy_pct   = 100;
        code_mode = 0;
        fix_code[0] = 2;
        fix_code[1] = 5;
        inj_code[0] = 0;
        inj_code[1] = 0;

        repeat (3) @(negedge clk);
        reset_checks("reset");
        rst_n = 1'b1;

        inj_v = 2'b01;
        inj_code[0] = 4;
        run(8, 1'b0);
        check("single_sum", 32'(sum), 32'hF);

        inj_v = 2'b10;
        inj_code[1] = 11;
        run(8, 1'b0);
        check("invalid_err_cnt", 32'(err_cnt), 32'd1);
        check("invalid_sum", 32'(sum), 32'hF);

        raise_pct = 100;
        run(13, 1'b0);
        raise_pct = 0;
        run(12, 1'b0);

        code_mode = 3;
        raise_pct = 50;
        rdy_pct   = 25;
        run(300, 1'b0);

        code_mode = 1;
        raise_pct = 40;
        drop_pct  = 10;
        rdy_pct   = 60;
        run(2000, 1'b1);
        check("reset_seen", 32'(rst_done), 32'd1);

        code_mode = 2;
        raise_pct = 100;
        drop_pct  = 0;
        rdy_pct   = 100;
        run(1000, 1'b0);
        check("sat_err_cnt", 32'(err_cnt), 32'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
